// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared ARC4 state encoding and constants
package arc4_pkg;

  localparam logic [7:0] MSG_LEN_ADDR = 8'd0;
  localparam int         SBOX_SIZE    = 256;

  typedef enum logic [3:0] {
    IDLE,
    RD_LEN,
    WR_LEN,
    INC_I,
    RD_SI,
    RD_SJ,
    WR_SI,
    WR_SJ,
    RD_PAD,
    RD_CT,
    WR_PT,
    DONE
  } state_t;

  // Read states hold for one extra cycle while the RAM returns data
  function automatic logic is_read_state(state_t s);
    return (s == RD_LEN) || (s == RD_SI) || (s == RD_SJ) ||
           (s == RD_PAD) || (s == RD_CT);
  endfunction

endpackage

// File: rtl/prga_unit.sv
// rtl/prga_unit.sv - ARC4 keystream generator and ciphertext decryptor
module prga_unit
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  state_t     state_q, state_d;
  logic       wait_q;
  logic [7:0] i_q, j_q, len_q, si_q, sj_q, pad_q;
  logic [8:0] k_q;

  // wait_q high marks the cycle in which read data is valid
  logic rd_valid;
  assign rd_valid = wait_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= is_read_state(state_q) && !wait_q;
    end
  end

  // Next-state and RAM port drive
  always_comb begin
    state_d   = state_q;
    rdy       = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (en) state_d = RD_LEN;
      end
      RD_LEN: begin
        ct_addr = MSG_LEN_ADDR;
        if (rd_valid) state_d = WR_LEN;
      end
      WR_LEN: begin
        pt_addr   = MSG_LEN_ADDR;
        pt_wrdata = len_q;
        pt_wren   = 1'b1;
        state_d   = (len_q == 8'd0) ? DONE : INC_I;
      end
      INC_I: state_d = RD_SI;
      RD_SI: begin
        s_addr = i_q;
        if (rd_valid) state_d = RD_SJ;
      end
      RD_SJ: begin
        s_addr = j_q;
        if (rd_valid) state_d = WR_SI;
      end
      WR_SI: begin
        s_addr   = i_q;
        s_wrdata = sj_q;
        s_wren   = 1'b1;
        state_d  = WR_SJ;
      end
      WR_SJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = RD_PAD;
      end
      RD_PAD: begin
        s_addr = si_q + sj_q;
        if (rd_valid) state_d = RD_CT;
      end
      RD_CT: begin
        ct_addr = k_q[7:0];
        if (rd_valid) state_d = WR_PT;
      end
      WR_PT: begin
        pt_addr   = k_q[7:0];
        pt_wrdata = pad_q;
        pt_wren   = 1'b1;
        state_d   = (k_q < {1'b0, len_q}) ? INC_I : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; pad_q is reused to hold ct^pad for the pt write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q   <= 8'd0;
      j_q   <= 8'd0;
      k_q   <= 9'd0;
      len_q <= 8'd0;
      si_q  <= 8'd0;
      sj_q  <= 8'd0;
      pad_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: if (en) begin
          i_q <= 8'd0;
          j_q <= 8'd0;
          k_q <= 9'd0;
        end
        RD_LEN: if (rd_valid) len_q <= ct_rddata;
        INC_I: begin
          i_q <= i_q + 8'd1;
          k_q <= k_q + 9'd1;
        end
        RD_SI: if (rd_valid) begin
          si_q <= s_rddata;
          j_q  <= j_q + s_rddata;
        end
        RD_SJ:  if (rd_valid) sj_q <= s_rddata;
        RD_PAD: if (rd_valid) pad_q <= s_rddata;
        RD_CT:  if (rd_valid) pad_q <= pad_q ^ ct_rddata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prga_unit.sv
// tb/tb_prga_unit.sv - scoreboard bench for prga_unit
module tb_prga_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;

  prga_unit dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem  [256];
  logic [7:0] s_init [256];
  logic [7:0] m_s    [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic       load_s = 1'b0;

  // Synchronous RAM models with one-cycle read latency
  always @(posedge clk) begin
    if (load_s) s_mem <= s_init;
    else if (s_wren) s_mem[s_addr] <= s_wrdata;
    if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int pt_wr_cnt = 0;
  int s_wr_cnt = 0;
  int overlap_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop one expected pt write per observed strobe
  always @(negedge clk) begin
    if (s_wren) s_wr_cnt++;
    if (s_wren && pt_wren) overlap_cnt++;
    if (pt_wren) begin
      pt_wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_write", {24'd0, pt_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sb_pt_addr", {24'd0, pt_addr}, {24'd0, e.a});
        chk("sb_pt_data", {24'd0, pt_wrdata}, {24'd0, e.d});
      end
    end
  end

  task automatic load_sbox();
    load_s = 1'b1;
    @(posedge clk);
    #1 load_s = 1'b0;
    m_s = s_init;
  endtask

  task automatic sbox_identity();
    for (int n = 0; n < 256; n++) s_init[n] = n[7:0];
    load_sbox();
  endtask

  task automatic sbox_random();
    logic [7:0] t;
    int r;
    for (int n = 0; n < 256; n++) s_init[n] = n[7:0];
    for (int n = 255; n > 0; n--) begin
      r = $urandom_range(n, 0);
      t = s_init[n];
      s_init[n] = s_init[r];
      s_init[r] = t;
    end
    load_sbox();
  endtask

  // Software ARC4 PRGA: pushes expected pt writes and updates model S
  task automatic model_msg();
    logic [7:0] i, j, si, sj, pad;
    int len;
    wr_t e;
    len = ct_mem[0];
    e.a = 8'd0; e.d = ct_mem[0];
    exp_q.push_back(e);
    i = 8'd0; j = 8'd0;
    for (int k = 1; k <= len; k++) begin
      i = i + 8'd1;
      si = m_s[i];
      j = j + si;
      sj = m_s[j];
      m_s[i] = sj;
      m_s[j] = si;
      pad = m_s[8'(si + sj)];
      e.a = k[7:0];
      e.d = ct_mem[k] ^ pad;
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_en();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    chk("rdy_low_after_accept", {31'd0, rdy}, 32'd0);
  endtask

  task automatic wait_rdy(input string tag, input int bound);
    int cyc;
    cyc = 0;
    while (!rdy && cyc < bound + 2) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
    chk({tag, "_latency_ok"}, {31'd0, (cyc <= bound)}, 32'd1);
  endtask

  task automatic check_after(input string tag);
    int mism;
    mism = 0;
    for (int n = 0; n < 256; n++) if (s_mem[n] !== m_s[n]) mism++;
    chk({tag, "_sbox_mismatches"}, mism, 32'd0);
    chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic run_msg(input string tag);
    int len;
    len = ct_mem[0];
    model_msg();
    pulse_en();
    wait_rdy(tag, 6 + 12 * len);
    @(negedge clk);
    check_after(tag);
  endtask

  initial begin
    int p0, s0, guard;
    en = 1'b0;
    rst_n = 1'b0;
    for (int n = 0; n < 256; n++) begin
      ct_mem[n] = 8'd0;
      pt_mem[n] = 8'd0;
      s_mem[n] = 8'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy", {31'd0, rdy}, 32'd1);
    chk("reset_strobes", {30'd0, s_wren, pt_wren}, 32'd0);
    chk("reset_addrs", {s_addr, ct_addr, pt_addr, 8'd0}, 32'd0);
    chk("reset_wrdata", {16'd0, s_wrdata, pt_wrdata}, 32'd0);
    rst_n = 1'b1;

    // One byte, identity S
    sbox_identity();
    ct_mem[0] = 8'd1; ct_mem[1] = 8'h00;
    run_msg("len1");
    chk("len1_pt1", {24'd0, pt_mem[1]}, 32'h02);

    // Two bytes, identity S: S[2]/S[3] swap
    sbox_identity();
    ct_mem[0] = 8'd2; ct_mem[1] = 8'h00; ct_mem[2] = 8'hFF;
    run_msg("len2");
    chk("len2_pt2", {24'd0, pt_mem[2]}, 32'hFA);
    chk("len2_s2_s3", {16'd0, s_mem[2], s_mem[3]}, 32'h0302);

    // Zero length
    sbox_identity();
    ct_mem[0] = 8'd0;
    p0 = pt_wr_cnt; s0 = s_wr_cnt;
    run_msg("len0");
    chk("len0_pt_writes", pt_wr_cnt - p0, 32'd1);
    chk("len0_s_writes", s_wr_cnt - s0, 32'd0);

    // en held high and re-pulsed while busy
    sbox_identity();
    ct_mem[0] = 8'd3; ct_mem[1] = 8'h11; ct_mem[2] = 8'h22; ct_mem[3] = 8'h33;
    p0 = pt_wr_cnt; s0 = s_wr_cnt;
    model_msg();
    @(negedge clk);
    en = 1'b1;
    repeat (20) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_busy", {31'd0, rdy}, 32'd0);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_rdy("held", 6 + 12 * 3);
    repeat (10) @(negedge clk);
    chk("held_pt_writes", pt_wr_cnt - p0, 32'd4);
    chk("held_s_writes", s_wr_cnt - s0, 32'd6);
    check_after("held");

    // Reset during byte 5 of a 10-byte message
    sbox_identity();
    ct_mem[0] = 8'd10;
    for (int n = 1; n <= 10; n++) ct_mem[n] = 8'($urandom);
    model_msg();
    pulse_en();
    guard = 0;
    while (!(pt_wren && pt_addr == 8'd4) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_reached_k4", {31'd0, pt_wren}, 32'd1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_idle_outputs", {29'd0, rdy, s_wren, pt_wren}, 32'h4);
    end
    rst_n = 1'b1;
    sbox_identity();
    for (int n = 1; n <= 10; n++) ct_mem[n] = 8'($urandom);
    run_msg("after_abort");

    // Full-length message with random S and ciphertext
    sbox_random();
    ct_mem[0] = 8'd255;
    for (int n = 1; n < 256; n++) ct_mem[n] = 8'($urandom);
    p0 = pt_wr_cnt;
    run_msg("len255");
    chk("len255_pt_writes", pt_wr_cnt - p0, 32'd256);
    chk("len255_pt0", {24'd0, pt_mem[0]}, 32'd255);

    chk("strobe_overlap", overlap_cnt, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
